// File: rtl/pipe_trace_pkg.sv
// Shared types and helpers for the pipeline trace buffer.
// Entry layout: stage s occupies {nop, pc} at bits [s*(PC_W+1) +: PC_W+1].
package pipe_trace_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DUMP  = 2'd3
   } trace_state_t;

   localparam int MAX_ENTRY_W = 1024;
   localparam int MAX_PC_W    = 64;

   function automatic int entry_w(input int stages, input int pc_w);
      return stages * (pc_w + 1);
   endfunction

   function automatic logic [MAX_PC_W:0] entry_stage(
      input logic [MAX_ENTRY_W-1:0] e,
      input int                     s,
      input int                     pc_w
   );
      logic [MAX_ENTRY_W-1:0] sh;
      logic [MAX_PC_W:0]      m;
      sh = e >> (s * (pc_w + 1));
      m  = '0;
      m  = ~m >> (MAX_PC_W - pc_w);
      return sh[MAX_PC_W:0] & m;
   endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module trace_ram
   import pipe_trace_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int PC_W   = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             we,
   input  logic [AW-1:0]                    waddr,
   input  logic [entry_w(STAGES, PC_W)-1:0] wdata,
   input  logic [AW-1:0]                    raddr,
   output logic [entry_w(STAGES, PC_W)-1:0] rdata
);

   localparam int W = entry_w(STAGES, PC_W);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular pipeline trace capture with retire-PC trigger and oldest-first drain.
// Optional per-stage bubble counters: define PIPE_TRACE_BUBBLE_CNT_EN.
module pipe_trace_buffer
   import pipe_trace_pkg::*;
#(
   parameter int STAGES    = 5,
   parameter int PC_W      = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [STAGES*PC_W-1:0]           stage_pc,
   input  logic [STAGES-1:0]                stage_nop,
   input  logic                             arm,
   input  logic [PC_W-1:0]                  trig_pc,
   input  logic                             rd_ready,
   output logic                             rd_valid,
   output logic [entry_w(STAGES, PC_W)-1:0] rd_data,
   output logic                             rd_last,
   output logic                             busy,
   output logic [31:0]                      retired
`ifdef PIPE_TRACE_BUBBLE_CNT_EN
   ,
   output logic [STAGES*16-1:0]             bubble_cnt
`endif
);

   localparam int EW = entry_w(STAGES, PC_W);
   localparam int AW = $clog2(DEPTH);

   if (POST_TRIG >= DEPTH) begin : g_chk_post
      $error("pipe_trace_buffer: POST_TRIG must be < DEPTH");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
      $error("pipe_trace_buffer: DEPTH must be a power of two >= 4");
   end

   trace_state_t  state;
   logic [AW-1:0] wr_ptr, rd_ptr, post_cnt, wr_ptr_nxt;
   logic [AW:0]   fill, rd_cnt, fill_nxt;
   logic [EW-1:0] wr_entry;
   logic [PC_W-1:0] wb_pc;
   logic          wb_nop, wr_en, trig_hit, last_wr, xfer;

   for (genvar s = 0; s < STAGES; s++) begin : g_entry
      assign wr_entry[s*(PC_W+1) +: PC_W+1] =
         {stage_nop[s], stage_pc[s*PC_W +: PC_W]};
   end

   assign wb_pc      = stage_pc[(STAGES-1)*PC_W +: PC_W];
   assign wb_nop     = stage_nop[STAGES-1];
   assign wr_en      = (state == ARMED) || (state == POST);
   assign trig_hit   = (state == ARMED) && !wb_nop && (wb_pc == trig_pc);
   assign last_wr    = (trig_hit && POST_TRIG == 0) ||
                       (state == POST && post_cnt == AW'(1));
   assign xfer       = rd_valid && rd_ready;
   assign wr_ptr_nxt = wr_ptr + 1'b1;
   assign fill_nxt   = (fill == (AW+1)'(DEPTH)) ? fill : fill + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         post_cnt <= '0;
         fill     <= '0;
         rd_cnt   <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         busy     <= 1'b0;
         retired  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (arm) begin
                  state   <= ARMED;
                  busy    <= 1'b1;
                  wr_ptr  <= '0;
                  fill    <= '0;
                  retired <= '0;
               end
            end
            ARMED, POST: begin
               wr_ptr <= wr_ptr_nxt;
               fill   <= fill_nxt;
               if (!wb_nop) retired <= retired + 32'd1;
               if (last_wr) begin
                  // Oldest valid slot; a full buffer wraps to wr_ptr itself.
                  state    <= DUMP;
                  rd_ptr   <= wr_ptr_nxt - fill_nxt[AW-1:0];
                  rd_cnt   <= fill_nxt;
                  rd_valid <= 1'b1;
                  rd_last  <= (fill_nxt == (AW+1)'(1));
               end else if (trig_hit) begin
                  state    <= POST;
                  post_cnt <= AW'(POST_TRIG);
               end else if (state == POST) begin
                  post_cnt <= post_cnt - 1'b1;
               end
            end
            DUMP: begin
               if (xfer) begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  rd_cnt  <= rd_cnt - 1'b1;
                  rd_last <= (rd_cnt == (AW+1)'(2));
                  if (rd_last) begin
                     state    <= IDLE;
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                     busy     <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   trace_ram #(
      .STAGES(STAGES),
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (wr_en),
      .waddr(wr_ptr),
      .wdata(wr_entry),
      .raddr(rd_ptr),
      .rdata(rd_data)
   );

`ifdef PIPE_TRACE_BUBBLE_CNT_EN
   always_ff @(posedge clk) begin
      if (reset || (state == IDLE && arm)) begin
         bubble_cnt <= '0;
      end else if (wr_en) begin
         for (int s = 0; s < STAGES; s++) begin
            if (stage_nop[s] && bubble_cnt[s*16 +: 16] != 16'hFFFF)
               bubble_cnt[s*16 +: 16] <= bubble_cnt[s*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule
